spi_tx_sequencer: RTL and testbench
===================================

Name: spi_tx_sequencer

Overview:
Frame-level controller that drains a TX fifo into the SPI master byte shifter. On a start request it asserts chip select and pops exactly burst_len words from the fifo, one per shifter transaction. It then releases chip select and signals completion. Sits between the TX fifo (read_enable / data_output / fifo_empty) and the SPI shift register.

Parameters:
DATA_WIDTH, 8, word width; matches the fifo and shifter.
MAX_BURST, 256, largest legal burst_len; BL_W = $clog2(MAX_BURST)+1.
CS_SETUP_CYCLES, 2, clk cycles from cs_n falling to the first shift_start; legal range >= 1.
CS_HOLD_CYCLES, 2, clk cycles from the last shift_done to cs_n rising; legal range >= 1.
TIMEOUT_CYCLES, 1024, underflow stall limit; used only when SPI_SEQ_TIMEOUT_EN is defined.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
start  in  1  one-cycle frame request
burst_len  in  BL_W  words in the frame; sampled on an accepted start
fifo_data  in  DATA_WIDTH  fifo head word (combinational fifo output)
fifo_empty  in  1  fifo has no entries
fifo_read_enable  out  1  one-cycle pop of the fifo head
shift_data  out  DATA_WIDTH  word presented to the shifter
shift_start  out  1  one-cycle shifter launch
shift_done  in  1  one-cycle pulse when the shifter finishes a word
cs_n  out  1  SPI chip select, active-low
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse when a frame ends
words_left  out  BL_W  words remaining in the current frame
aborted  out  1  one-cycle pulse on timeout abort (tied 0 without the macro)

Behaviour:
- Reset values (asynchronous): state=IDLE, cs_n=1, busy=0, fifo_read_enable=0, shift_start=0, frame_done=0, aborted=0, shift_data=0, words_left=0, all counters 0.
- Reset asserted mid-frame: abort immediately, cs_n=1 combinationally via the async clear, no frame_done pulse.
- States: IDLE, SETUP, LOAD, SHIFT, HOLD. All outputs are registered.
- IDLE:
  - start=1 and burst_len in 1..MAX_BURST: latch burst_len into words_left, drive cs_n=0 next cycle, enter SETUP.
  - start with burst_len=0 or > MAX_BURST: ignored; stay IDLE.
- SETUP: count CS_SETUP_CYCLES cycles with cs_n=0, then enter LOAD.
- LOAD:
  - fifo_empty=1: stall in LOAD, cs_n held low (underflow stall).
  - fifo_empty=0: in one cycle register shift_data<=fifo_data, pulse shift_start=1 and fifo_read_enable=1 together, decrement words_left, enter SHIFT.
  - The pop and the data capture use the same fifo head word.
- SHIFT: wait for shift_done.
  - shift_done with words_left!=0: enter LOAD.
  - shift_done with words_left==0: enter HOLD.
  - Back-to-back latency: shift_done at cycle N gives the earliest next shift_start at N+2.
- HOLD: count CS_HOLD_CYCLES cycles, then cs_n=1, frame_done pulses for one cycle, enter IDLE. busy drops in the same cycle cs_n rises.
- Ignored events:
  - start while busy=1.
  - shift_done outside SHIFT.
- fifo_read_enable never asserts while fifo_empty=1 and never asserts more than once per word.
- Counters saturate and never wrap; words_left never underflows below 0.

Optional Feature:
Macro SPI_SEQ_TIMEOUT_EN.
- Defined:
  - A stall counter runs while in LOAD with fifo_empty=1 and clears on any pop.
  - When it reaches TIMEOUT_CYCLES: enter HOLD, set words_left=0, pulse aborted for one cycle.
  - The frame then closes normally through HOLD (cs_n rises, frame_done pulses).
- Not defined: no stall counter; LOAD waits indefinitely; aborted is constant 0.

Test Plan:
1. Fifo preloaded with 0xA1,0xB2,0xC3; start with burst_len=3; shifter returns shift_done 8 cycles after each shift_start -> shift_data sequence A1,B2,C3; exactly 3 fifo_read_enable pulses; cs_n low 2 cycles before the first shift_start and high 2 cycles after the third shift_done; one frame_done pulse.
2. start with burst_len=0, then start with burst_len=MAX_BURST+1 -> cs_n stays 1, busy stays 0, no fifo pops.
3. burst_len=2 with fifo empty; push 0x55 at cycle 20 and 0x66 at cycle 40 -> cs_n stays low throughout; shift_start for 0x55 the cycle after fifo_empty falls; frame completes normally.
4. Assert start and spurious shift_done pulses during SHIFT/HOLD of a running frame -> no second frame, no extra pops, words_left unaffected by the spurious pulses.
5. Assert reset during the second word of a 4-word frame -> cs_n=1 and busy=0 immediately; no frame_done; next start with burst_len=1 runs normally.
6. SPI_SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, burst_len=2, fifo holds one word -> one word sent, aborted pulses after 16 stall cycles, cs_n rises CS_HOLD_CYCLES later, frame_done pulses.

Source files
------------

// File: rtl/spi_tx_sequencer.sv
// spi_tx_sequencer: drains burst_len fifo words into the SPI shifter in one cs_n frame.
// Optional underflow timeout abort is compiled in with `define SPI_SEQ_TIMEOUT_EN.
module spi_tx_sequencer #(
  parameter  int DATA_WIDTH      = 8,
  parameter  int MAX_BURST       = 256,
  parameter  int CS_SETUP_CYCLES = 2,
  parameter  int CS_HOLD_CYCLES  = 2,
  parameter  int TIMEOUT_CYCLES  = 1024,
  localparam int BL_W            = $clog2(MAX_BURST) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BL_W-1:0]       burst_len,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_read_enable,
  output logic [DATA_WIDTH-1:0] shift_data,
  output logic                  shift_start,
  input  logic                  shift_done,
  output logic                  cs_n,
  output logic                  busy,
  output logic                  frame_done,
  output logic [BL_W-1:0]       words_left,
  output logic                  aborted
);

  localparam int CMAX = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ?
                        CS_SETUP_CYCLES : CS_HOLD_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOAD,
    S_SHIFT,
    S_HOLD
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [BL_W-1:0]       r_words;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_cs_n;
  logic                  r_busy;
  logic                  r_rd;
  logic                  r_start;
  logic                  r_fd;
  logic                  w_bl_ok;

  assign w_bl_ok = (burst_len != '0) &&
                   (burst_len <= BL_W'(MAX_BURST));

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
  logic [SW-1:0] r_stall;
  logic          r_abort;
  assign aborted = r_abort;
`else
  // Constant low; the parameter only matters in the timeout build.
  assign aborted = (TIMEOUT_CYCLES < 0);
`endif

  assign fifo_read_enable = r_rd;
  assign shift_data       = r_data;
  assign shift_start      = r_start;
  assign cs_n             = r_cs_n;
  assign busy             = r_busy;
  assign frame_done       = r_fd;
  assign words_left       = r_words;

  // The cycle that launches or sees shift_done counts toward setup/hold,
  // so the wait states start their counters at 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_words <= '0;
      r_data  <= '0;
      r_cs_n  <= 1'b1;
      r_busy  <= 1'b0;
      r_rd    <= 1'b0;
      r_start <= 1'b0;
      r_fd    <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
      r_stall <= '0;
      r_abort <= 1'b0;
`endif
    end else begin
      r_rd    <= 1'b0;
      r_start <= 1'b0;
      r_fd    <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
      r_abort <= 1'b0;
`endif
      unique case (r_state)
        S_IDLE: begin
          if (start && w_bl_ok) begin
            r_words <= burst_len;
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= CW'(1);
`ifdef SPI_SEQ_TIMEOUT_EN
            r_stall <= '0;
`endif
            r_state <= (CS_SETUP_CYCLES > 1) ? S_SETUP : S_LOAD;
          end
        end
        S_SETUP: begin
          if (r_cnt >= CW'(CS_SETUP_CYCLES - 1)) begin
            r_state <= S_LOAD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_LOAD: begin
          if (!fifo_empty) begin
            r_data  <= fifo_data;
            r_start <= 1'b1;
            r_rd    <= 1'b1;
            if (r_words != '0) begin
              r_words <= r_words - 1'b1;
            end
            r_state <= S_SHIFT;
`ifdef SPI_SEQ_TIMEOUT_EN
            r_stall <= '0;
          end else if (r_stall >= SW'(TIMEOUT_CYCLES - 1)) begin
            r_words <= '0;
            r_abort <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_HOLD;
          end else begin
            r_stall <= r_stall + 1'b1;
`endif
          end
        end
        S_SHIFT: begin
          if (shift_done) begin
            if (r_words != '0) begin
              r_state <= S_LOAD;
            end else if (CS_HOLD_CYCLES == 1) begin
              r_cs_n  <= 1'b1;
              r_busy  <= 1'b0;
              r_fd    <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_cnt   <= CW'(1);
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (r_cnt >= CW'(CS_HOLD_CYCLES - 1)) begin
            r_cs_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_fd    <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Directed bench for spi_tx_sequencer: a table of frame requests plus
// hand-written latency, stall, spurious-event, reset and timeout sequences.
`timescale 1ns/1ps
module tb_spi_tx_sequencer;
  localparam int DW   = 8;
  localparam int MAXB = 256;
  localparam int BLW  = $clog2(MAXB) + 1;
  localparam int TMO  = 16;
`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int P1 = 10;
`else
  localparam int P1 = 18;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [BLW-1:0] burst_len = '0;
  logic [DW-1:0]  fifo_data;
  logic           fifo_empty;
  logic           fifo_read_enable;
  logic [DW-1:0]  shift_data;
  logic           shift_start;
  logic           shift_done;
  logic           cs_n;
  logic           busy;
  logic           frame_done;
  logic [BLW-1:0] words_left;
  logic           aborted;
  logic           sd_model = 1'b0;
  logic           sd_spur = 1'b0;

  assign shift_done = sd_model | sd_spur;

  spi_tx_sequencer #(
    .DATA_WIDTH     (DW),
    .MAX_BURST      (MAXB),
    .CS_SETUP_CYCLES(2),
    .CS_HOLD_CYCLES (2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .burst_len       (burst_len),
    .fifo_data       (fifo_data),
    .fifo_empty      (fifo_empty),
    .fifo_read_enable(fifo_read_enable),
    .shift_data      (shift_data),
    .shift_start     (shift_start),
    .shift_done      (shift_done),
    .cs_n            (cs_n),
    .busy            (busy),
    .frame_done      (frame_done),
    .words_left      (words_left),
    .aborted         (aborted)
  );

  initial forever #5 clk = ~clk;

  // fifo model: pushes are queued by the stimulus and applied on the clock
  logic [7:0] q[$];
  logic [7:0] pend[0:1023];
  int pend_wr = 0, pend_rd = 0, flush_req = 0, flush_ack = 0;

  always @(posedge clk) begin
    if (flush_req != flush_ack) begin
      q.delete();
      flush_ack = flush_req;
    end else if (fifo_read_enable && q.size() != 0) begin
      void'(q.pop_front());
    end
    while (pend_rd < pend_wr) begin
      q.push_back(pend[pend_rd]);
      pend_rd++;
    end
    fifo_empty <= (q.size() == 0);
    fifo_data  <= (q.size() != 0) ? q[0] : 8'h00;
  end

  // shifter model and event monitor
  int cyc = 0, sd_tmr = 0, sd_cyc = 0;
  int n_pop = 0, n_pop_empty = 0, n_ss = 0, n_fd = 0, n_ab = 0;
  int n_csf = 0, n_csr = 0, n_bc = 0;
  int cs_fall = 0, cs_rise = 0, ab_cyc = 0, fd_cyc = 0;
  logic prev_cs = 1'b1, prev_fe = 1'b1;
  logic [7:0] ss_log[$];
  int ss_cyc[$];
  int fe_log[$];

  always @(negedge clk) begin
    cyc++;
    sd_model = 1'b0;
    if (reset) sd_tmr = 0;
    else if (shift_start) sd_tmr = 8;
    else if (sd_tmr > 0) begin
      sd_tmr--;
      if (sd_tmr == 0) begin
        sd_model = 1'b1;
        sd_cyc = cyc;
      end
    end
    if (fifo_read_enable) begin
      n_pop++;
      if (fifo_empty) n_pop_empty++;
    end
    if (shift_start) begin
      n_ss++;
      ss_log.push_back(shift_data);
      ss_cyc.push_back(cyc);
    end
    if (frame_done) begin
      n_fd++;
      fd_cyc = cyc;
    end
    if (aborted) begin
      n_ab++;
      ab_cyc = cyc;
    end
    if (prev_cs && !cs_n) begin
      n_csf++;
      cs_fall = cyc;
    end
    if (!prev_cs && cs_n) begin
      n_csr++;
      cs_rise = cyc;
    end
    if (prev_fe && !fifo_empty) fe_log.push_back(cyc);
    prev_cs = cs_n;
    prev_fe = fifo_empty;
    if (busy != !cs_n) n_bc++;
  end

  int total = 0, bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] d);
    pend[pend_wr] = d;
    pend_wr++;
  endtask

  task automatic flush();
    flush_req++;
    tick(1);
  endtask

  task automatic go(input int bl);
    start = 1'b1;
    burst_len = BLW'(bl);
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_fd(input string nm, input int base, input int budget);
    int k = 0;
    while (n_fd == base && k < budget) begin
      tick(1);
      k++;
    end
    chk(nm, n_fd - base, 1);
  endtask

  typedef struct {
    int bl;
    int npre;
    int pops;
    int fds;
  } vec_t;

  vec_t tbl[6];
  int b_pop, b_ss, b_fd, b_csf, b_csr, b_fe, b_ab, mis, k;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{3, 3, 3, 1};
    tbl[1] = '{0, 2, 0, 0};
    tbl[2] = '{MAXB + 1, 2, 0, 0};
    tbl[3] = '{1, 1, 1, 1};
    tbl[4] = '{2, 2, 2, 1};
    tbl[5] = '{MAXB, MAXB, MAXB, 1};

    tick(3);
    chk("rst cs_n", int'(cs_n), 1);
    chk("rst busy", int'(busy), 0);
    chk("rst rd_en", int'(fifo_read_enable), 0);
    chk("rst shift_start", int'(shift_start), 0);
    chk("rst frame_done", int'(frame_done), 0);
    chk("rst aborted", int'(aborted), 0);
    chk("rst shift_data", int'(shift_data), 0);
    chk("rst words_left", int'(words_left), 0);
    reset = 1'b0;
    tick(2);

    for (int r = 0; r < 6; r++) begin
      flush();
      for (int i = 0; i < tbl[r].npre; i++) push(8'(r * 16 + i * 3 + 1));
      tick(2);
      b_pop = n_pop; b_ss = n_ss; b_fd = n_fd; b_csf = n_csf;
      go(tbl[r].bl);
      k = 0;
      while (n_fd == b_fd && k < tbl[r].npre * 12 + 40) begin
        tick(1);
        k++;
      end
      tick(3);
      chk($sformatf("row%0d pops", r), n_pop - b_pop, tbl[r].pops);
      chk($sformatf("row%0d starts", r), n_ss - b_ss, tbl[r].pops);
      chk($sformatf("row%0d frame_done", r), n_fd - b_fd, tbl[r].fds);
      chk($sformatf("row%0d cs falls", r), n_csf - b_csf, tbl[r].fds);
      mis = 0;
      for (int i = 0; i < tbl[r].pops; i++) begin
        if (b_ss + i >= ss_log.size()) mis++;
        else if (ss_log[b_ss + i] != 8'(r * 16 + i * 3 + 1)) mis++;
      end
      chk($sformatf("row%0d data", r), mis, 0);
      chk($sformatf("row%0d words_left", r), int'(words_left), 0);
      chk($sformatf("row%0d busy", r), int'(busy), 0);
    end

    // frame timing: setup, back-to-back and hold latencies
    flush();
    push(8'hA1); push(8'hB2); push(8'hC3);
    tick(2);
    b_pop = n_pop; b_ss = n_ss; b_fd = n_fd;
    go(3);
    wait_fd("t1 frame", b_fd, 100);
    tick(3);
    chk("t1 pops", n_pop - b_pop, 3);
    chk("t1 starts", n_ss - b_ss, 3);
    if (n_ss - b_ss >= 3) begin
      chk("t1 d0", int'(ss_log[b_ss]), 'hA1);
      chk("t1 d1", int'(ss_log[b_ss + 1]), 'hB2);
      chk("t1 d2", int'(ss_log[b_ss + 2]), 'hC3);
      chk("t1 setup", ss_cyc[b_ss] - cs_fall, 2);
      chk("t1 b2b", ss_cyc[b_ss + 1] - ss_cyc[b_ss], 10);
    end
    chk("t1 hold", cs_rise - sd_cyc, 2);
    chk("t1 fd with cs rise", fd_cyc, cs_rise);

    // underflow stall with cs_n held low
    flush();
    tick(2);
    b_pop = n_pop; b_ss = n_ss; b_fd = n_fd;
    b_csf = n_csf; b_csr = n_csr; b_fe = fe_log.size();
    go(2);
    tick(P1);
    chk("t3 cs low in stall", int'(cs_n), 0);
    push(8'h55);
    tick(20);
    chk("t3 cs low in stall2", int'(cs_n), 0);
    push(8'h66);
    wait_fd("t3 frame", b_fd, 200);
    tick(3);
    chk("t3 starts", n_ss - b_ss, 2);
    chk("t3 pops", n_pop - b_pop, 2);
    chk("t3 cs rises", n_csr - b_csr, 1);
    chk("t3 cs falls", n_csf - b_csf, 1);
    if (n_ss - b_ss >= 2 && fe_log.size() - b_fe >= 2) begin
      chk("t3 d0", int'(ss_log[b_ss]), 'h55);
      chk("t3 d1", int'(ss_log[b_ss + 1]), 'h66);
      chk("t3 lat0", ss_cyc[b_ss] - fe_log[b_fe], 1);
      chk("t3 lat1", ss_cyc[b_ss + 1] - fe_log[b_fe + 1], 1);
    end

    // spurious start and shift_done while a frame runs
    flush();
    tick(2);
    b_pop = n_pop; b_ss = n_ss; b_fd = n_fd; b_csf = n_csf;
    go(2);
    sd_spur = 1'b1; start = 1'b1; burst_len = BLW'(1);
    tick(1);
    sd_spur = 1'b0; start = 1'b0;
    tick(4);
    sd_spur = 1'b1;
    tick(1);
    sd_spur = 1'b0;
    tick(1);
    chk("t4 wl in stall", int'(words_left), 2);
    chk("t4 no early pop", n_pop - b_pop, 0);
    push(8'h11); push(8'h22);
    k = 0;
    while (n_ss - b_ss < 1 && k < 50) begin
      tick(1);
      k++;
    end
    tick(2);
    start = 1'b1; burst_len = BLW'(5);
    tick(1);
    start = 1'b0;
    chk("t4 wl in shift", int'(words_left), 1);
    k = 0;
    while (!(n_ss - b_ss == 2 && sd_tmr == 0) && k < 100) begin
      tick(1);
      k++;
    end
    tick(1);
    sd_spur = 1'b1; start = 1'b1; burst_len = BLW'(1);
    tick(1);
    sd_spur = 1'b0; start = 1'b0;
    tick(30);
    chk("t4 frames", n_fd - b_fd, 1);
    chk("t4 cs falls", n_csf - b_csf, 1);
    chk("t4 pops", n_pop - b_pop, 2);
    chk("t4 starts", n_ss - b_ss, 2);
    chk("t4 words_left", int'(words_left), 0);
    chk("t4 busy", int'(busy), 0);

    // reset in the middle of a frame, then a clean one-word frame
    flush();
    push(8'h41); push(8'h42); push(8'h43); push(8'h44);
    tick(2);
    b_fd = n_fd;
    go(4);
    k = 0;
    while (n_ss < b_ss + 4 && k < 100) begin
      b_ss = b_ss;
      tick(1);
      k++;
      if (n_ss - b_ss >= 4) k = 100;
    end
    tick(2);
    #2 reset = 1'b1;
    #1;
    chk("t5 cs_n on reset", int'(cs_n), 1);
    chk("t5 busy on reset", int'(busy), 0);
    chk("t5 wl on reset", int'(words_left), 0);
    tick(2);
    reset = 1'b0;
    tick(20);
    chk("t5 no frame_done", n_fd - b_fd, 0);
    flush();
    push(8'h3C);
    tick(2);
    b_pop = n_pop; b_ss = n_ss; b_fd = n_fd;
    go(1);
    wait_fd("t5 next frame", b_fd, 60);
    tick(3);
    chk("t5 pops", n_pop - b_pop, 1);
    chk("t5 starts", n_ss - b_ss, 1);
    if (n_ss - b_ss >= 1) chk("t5 data", int'(ss_log[b_ss]), 'h3C);

`ifdef SPI_SEQ_TIMEOUT_EN
    // underflow timeout closes the frame through HOLD
    flush();
    push(8'h77);
    tick(2);
    b_pop = n_pop; b_ss = n_ss; b_fd = n_fd; b_ab = n_ab;
    go(2);
    wait_fd("t6 frame", b_fd, 200);
    tick(3);
    chk("t6 pops", n_pop - b_pop, 1);
    chk("t6 starts", n_ss - b_ss, 1);
    chk("t6 aborts", n_ab - b_ab, 1);
    chk("t6 stall len", ab_cyc - sd_cyc, TMO + 1);
    chk("t6 hold", cs_rise - ab_cyc, 2);
    chk("t6 fd with cs rise", fd_cyc, cs_rise);
    chk("t6 words_left", int'(words_left), 0);
`else
    chk("no aborts", n_ab, 0);
`endif

    chk("pop while empty", n_pop_empty, 0);
    chk("busy vs cs_n", n_bc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
